// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: add/sub, OR and set-less-than behind a single
// valid/ready pipeline register, with a sticky overflow flag.
module alu_exec_stage #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub_ctr,
   input  logic             ov_ctr,
   input  logic             sig_ctr,
   input  logic [1:0]       op_ctr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             ov_sticky
);

   typedef enum logic [1:0] {
      OpAdd  = 2'b00,
      OpOr   = 2'b01,
      OpSlt  = 2'b10,
      OpRsvd = 2'b11
   } alu_op_e;

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic             sticky_q, sticky_d;

   logic             accept;
   logic [WIDTH-1:0] bx;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             sov;
   logic             less;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;

   assign in_ready = ~valid_q | out_ready;
   assign accept   = in_valid & in_ready;

   // Shared adder; subtraction is A + ~B + 1 with the carry-in taken from sub_ctr.
   assign bx          = sub_ctr ? ~b : b;
   assign {cout, sum} = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub_ctr};
   assign sov         = (a[WIDTH-1] == bx[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
   assign less        = sig_ctr ? (sum[WIDTH-1] ^ sov) : ~cout;

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      unique case (alu_op_e'(op_ctr))
         OpAdd: begin
            alu_res = sum;
            alu_ovf = ov_ctr & sov;
         end
         OpOr:   alu_res = a | b;
         OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, less};
         OpRsvd: alu_res = '0;
         default: alu_res = '0;
      endcase
   end

   // Output fields only load on accept, so unaccepted (possibly X) inputs never leak out.
   always_comb begin
      valid_d  = accept | (valid_q & ~out_ready);
      result_d = result_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      sticky_d = sticky_q;
      if (accept) begin
         result_d = alu_res;
         zero_d   = (alu_res == '0);
         ovf_d    = alu_ovf;
         sticky_d = sticky_q | alu_ovf;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b1;
         ovf_q    <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         valid_q  <= valid_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         sticky_q <= sticky_d;
      end
   end

   assign out_valid = valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign overflow  = ovf_q;
   assign ov_sticky = sticky_q;

endmodule
